// File: rtl/loop3_drain.sv
// loop3_drain: captures one accumulated 1024-bit channel-loop vector and
// streams it out as NBEATS 64-bit beats over a valid/ready handshake.
// Optional ReLU clamps negative 16-bit lanes to zero on the way out.
`timescale 1ns/1ps
module loop3_drain #(
  parameter int NBEATS  = 16,
  parameter bit RELU_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          loop3_regdata_v,
  input  logic [1023:0] loop3_regdata,
  input  logic          out_ready,
  output logic          halt,
  output logic          out_v,
  output logic [63:0]   out_data,
  output logic [3:0]    out_idx,
  output logic          out_last,
  output logic [15:0]   frame_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NBEATS - 1);

  state_t        state_reg, state_next;
  logic [1023:0] buf_reg;
  logic [63:0]   data_reg;
  logic [3:0]    idx_reg;
  logic          v_reg;
  logic          halt_reg;
  logic [15:0]   frame_reg;

  logic          capture;
  logic          advance;
  logic          finish;
  logic [3:0]    beat_sel;
  logic [63:0]   beat_src;
  logic [63:0]   beat_relu;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and per-cycle datapath strobes
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (loop3_regdata_v) begin
          capture    = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_reg == LAST_IDX) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Beat 0 comes straight from the input word on capture; later beats come
  // from the buffer. Either way the result is registered before the port.
  assign beat_sel = idx_reg + 4'd1;
  assign beat_src = capture ? loop3_regdata[63:0] : buf_reg[{beat_sel, 6'd0} +: 64];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      if (RELU_EN) begin : g_relu
        assign beat_relu[16*gi +: 16] = beat_src[16*gi + 15] ? 16'h0000 : beat_src[16*gi +: 16];
      end else begin : g_pass
        assign beat_relu[16*gi +: 16] = beat_src[16*gi +: 16];
      end
    end
  endgenerate

  // Vector buffer; contents are don't-care until the next capture
  always_ff @(posedge clk) begin
    if (capture) buf_reg <= loop3_regdata;
  end

  // Output registers, backpressure flag and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_reg  <= 1'b0;
      v_reg     <= 1'b0;
      idx_reg   <= 4'd0;
      data_reg  <= 64'd0;
      frame_reg <= 16'd0;
    end else begin
      halt_reg <= (state_next == SEND);
      if (capture) begin
        v_reg    <= 1'b1;
        idx_reg  <= 4'd0;
        data_reg <= beat_relu;
      end else if (advance) begin
        idx_reg  <= beat_sel;
        data_reg <= beat_relu;
      end else if (finish) begin
        v_reg     <= 1'b0;
        idx_reg   <= 4'd0;
        frame_reg <= frame_reg + 16'd1;
      end
    end
  end

  assign halt      = halt_reg;
  assign out_v     = v_reg;
  assign out_data  = data_reg;
  assign out_idx   = idx_reg;
  assign out_last  = v_reg && (idx_reg == LAST_IDX);
  assign frame_cnt = frame_reg;

endmodule

// File: tb/tb_loop3_drain.sv
// Directed bench for loop3_drain: basic drain, ReLU on/off, backpressure,
// back-to-back vectors, reset mid-drain and frame counter wrap.
`timescale 1ns/1ps
module tb_loop3_drain;

  logic          clk = 1'b0;
  logic          rst;
  logic          loop3_regdata_v;
  logic [1023:0] loop3_regdata;
  logic          out_ready;

  logic          halt, out_v, out_last;
  logic [63:0]   out_data;
  logic [3:0]    out_idx;
  logic [15:0]   frame_cnt;

  logic          halt0, out_v0, out_last0;
  logic [63:0]   out_data0;
  logic [3:0]    out_idx0;
  logic [15:0]   frame_cnt0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  loop3_drain #(.NBEATS(16), .RELU_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .loop3_regdata_v(loop3_regdata_v), .loop3_regdata(loop3_regdata),
    .out_ready(out_ready), .halt(halt), .out_v(out_v), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .frame_cnt(frame_cnt)
  );

  loop3_drain #(.NBEATS(16), .RELU_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .loop3_regdata_v(loop3_regdata_v), .loop3_regdata(loop3_regdata),
    .out_ready(out_ready), .halt(halt0), .out_v(out_v0), .out_data(out_data0),
    .out_idx(out_idx0), .out_last(out_last0), .frame_cnt(frame_cnt0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_beat(input logic [1023:0] vec, input int k, input bit relu);
    logic [15:0] lane;
    logic [63:0] b;
    b = '0;
    for (int j = 0; j < 4; j++) begin
      lane = vec[16*(4*k+j) +: 16];
      if (relu && lane[15]) lane = 16'h0000;
      b[16*j +: 16] = lane;
    end
    return b;
  endfunction

  // Present a vector at a negedge; the next posedge captures it.
  task automatic offer(input logic [1023:0] vec);
    loop3_regdata   = vec;
    loop3_regdata_v = 1'b1;
    #1;
    check("halt_no_comb_path", {63'd0, halt}, 64'd0);
    @(negedge clk);
  endtask

  // Follow a drain beat by beat from the first beat. Optionally stall at
  // beat 7 or pulse reset when beat rst_at is showing.
  task automatic drain(input logic [1023:0] vec, input int stall_len, input int rst_at,
                       output int cycles);
    int k = 0;
    int stalled = 0;
    bit done = 1'b0;
    cycles = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (!halt) begin
        done = 1'b1;
      end else begin
        cycles++;
        check($sformatf("out_v_b%0d", k), {63'd0, out_v}, 64'd1);
        check($sformatf("out_idx_b%0d", k), {60'd0, out_idx}, 64'(k));
        check($sformatf("out_last_b%0d", k), {63'd0, out_last}, {63'd0, k == 15});
        check($sformatf("out_data_b%0d", k), out_data, exp_beat(vec, k, 1'b1));
        if (k == rst_at) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          k = 16;
          done = 1'b1;
        end else begin
          if (k == 7 && stalled < stall_len) begin
            out_ready = 1'b0;
            stalled++;
          end else begin
            out_ready = 1'b1;
            k++;
          end
          @(negedge clk);
        end
      end
    end
    out_ready = 1'b1;
    check("drain_all_beats", 64'(k), 64'd16);
  endtask

  logic [1023:0] vec_a, vec_b, vec_r;
  int cyc;

  initial begin
    for (int i = 0; i < 64; i++) begin
      vec_a[16*i +: 16] = 16'(i);
      vec_b[16*i +: 16] = (i % 2 == 0) ? 16'(16'h8000 + i) : 16'(16'h0100 + i);
    end
    vec_r = vec_a;
    vec_r[63:0] = 64'h0005_FFFF_7FFF_8001;

    rst = 1'b1; loop3_regdata_v = 1'b0; loop3_regdata = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_v", {63'd0, out_v}, 64'd0);
    check("rst_halt", {63'd0, halt}, 64'd0);
    check("rst_idx", {60'd0, out_idx}, 64'd0);
    check("rst_last", {63'd0, out_last}, 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_frame", {48'd0, frame_cnt}, 64'd0);

    // Basic drain, captured on the first cycle after reset release
    rst = 1'b0;
    offer(vec_a);
    loop3_regdata_v = 1'b0;
    check("basic_beat0_const", out_data, 64'h0003_0002_0001_0000);
    drain(vec_a, 0, -1, cyc);
    check("basic_halt_cycles", 64'(cyc), 64'd16);
    check("basic_out_v_idle", {63'd0, out_v}, 64'd0);
    check("basic_frame", {48'd0, frame_cnt}, 64'd1);
    $display("[TB] basic drain: %0d cycles in SEND, frame_cnt=%0d", cyc, frame_cnt);

    // ReLU on vs off
    offer(vec_r);
    loop3_regdata_v = 1'b0;
    check("relu_on_low32", {32'd0, out_data[31:0]}, {32'd0, 32'h7FFF_0000});
    check("relu_off_low32", {32'd0, out_data0[31:0]}, {32'd0, 32'h7FFF_8001});
    check("relu_off_v", {63'd0, out_v0}, 64'd1);
    check("relu_off_halt", {63'd0, halt0}, 64'd1);
    check("relu_off_idx", {60'd0, out_idx0}, 64'd0);
    check("relu_off_last", {63'd0, out_last0}, 64'd0);
    drain(vec_r, 0, -1, cyc);
    check("relu_frame", {48'd0, frame_cnt}, 64'd2);
    $display("[TB] relu drain: %0d cycles, frame_cnt=%0d", cyc, frame_cnt);

    // Backpressure: 5 stalled cycles at beat 7
    offer(vec_b);
    loop3_regdata_v = 1'b0;
    drain(vec_b, 5, -1, cyc);
    check("bp_send_cycles", 64'(cyc), 64'd21);
    check("bp_frame", {48'd0, frame_cnt}, 64'd3);
    $display("[TB] backpressure drain: %0d cycles, frame_cnt=%0d", cyc, frame_cnt);

    // Back-to-back: valid stays high, second vector changes during SEND
    offer(vec_a);
    loop3_regdata = vec_b;
    drain(vec_a, 0, -1, cyc);
    check("b2b_bubble_v", {63'd0, out_v}, 64'd0);
    check("b2b_bubble_halt", {63'd0, halt}, 64'd0);
    @(negedge clk);
    loop3_regdata_v = 1'b0;
    drain(vec_b, 0, -1, cyc);
    check("b2b_second_cycles", 64'(cyc), 64'd16);
    check("b2b_frame", {48'd0, frame_cnt}, 64'd5);
    $display("[TB] back-to-back drain: frame_cnt=%0d", frame_cnt);

    // Reset while beat 9 is showing
    offer(vec_b);
    loop3_regdata_v = 1'b0;
    drain(vec_b, 0, 9, cyc);
    check("midrst_out_v", {63'd0, out_v}, 64'd0);
    check("midrst_halt", {63'd0, halt}, 64'd0);
    check("midrst_idx", {60'd0, out_idx}, 64'd0);
    check("midrst_frame", {48'd0, frame_cnt}, 64'd0);
    offer(vec_a);
    loop3_regdata_v = 1'b0;
    drain(vec_a, 0, -1, cyc);
    check("midrst_fresh_frame", {48'd0, frame_cnt}, 64'd1);
    $display("[TB] reset mid-drain then fresh drain: frame_cnt=%0d", frame_cnt);

    // Wrap: force the counter to FFFF, then one more drain
    force dut.frame_reg = 16'hFFFF;
    @(negedge clk);
    release dut.frame_reg;
    @(negedge clk);
    check("wrap_preload", {48'd0, frame_cnt}, 64'h0000_0000_0000_FFFF);
    offer(vec_r);
    loop3_regdata_v = 1'b0;
    drain(vec_r, 0, -1, cyc);
    check("wrap_frame", {48'd0, frame_cnt}, 64'd0);
    check("relu_off_frame", {48'd0, frame_cnt0}, 64'd2);
    $display("[TB] wrap drain: frame_cnt=%h", frame_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
